// File: rtl/msf_clock_pkg.sv
// Shared definitions for the HH:MM:SS seven-segment serial transmitter.
// Provides frame geometry, FSM state encoding and the frame packing helper.
package msf_clock_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int SEG_W      = 7;
    localparam int FRAME_W    = 48;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    // One byte per digit {dp, segments}; digit 5 lands in the top byte so
    // it leaves the MSB-first shifter first.
    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [NUM_DIGITS*SEG_W-1:0] seg,
        input logic [NUM_DIGITS-1:0]       dp,
        input logic                        inv
    );
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            f[d*8 +: 8] = {dp[d], seg[d*SEG_W +: SEG_W]};
        end
        return inv ? ~f : f;
    endfunction

endpackage

// File: rtl/ser_phase_timer.sv
// Phase timer: counts CLK_DIV cycles per phase, pulses phase_end_o on the
// last cycle. Ports: clk_i, rst_i, load_i (restart), en_i (run), phase_end_o.
module ser_phase_timer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic phase_end_o
);
    import msf_clock_pkg::*;

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign phase_end_o = (r_cnt == '0);

    // Reload on the terminal cycle so consecutive phases run back to back.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= RELOAD;
        end else if (en_i) begin
            if (r_cnt == '0) begin
                r_cnt <= RELOAD;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/seven_seg_shift_out.sv
// Serialises six seven-segment digits plus decimal points into a chain of
// 74HC595-style registers, then pulses the storage latch.
// Ports: clk_i, rst_i, seven_seg_hms_i[41:0], dp_i[5:0], start_i,
//        busy_o, done_o, ser_clk_o, ser_data_o, ser_latch_o.
module seven_seg_shift_out #(
    parameter int unsigned CLK_DIV        = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [41:0] seven_seg_hms_i,
    input  logic [5:0]  dp_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ser_clk_o,
    output logic        ser_data_o,
    output logic        ser_latch_o
);
    import msf_clock_pkg::*;

    state_t             r_state;
    logic [FRAME_W-1:0] r_shreg;
    logic [5:0]         r_bitcnt;
    logic               r_busy;
    logic               r_done;
    logic               r_sclk;
    logic               r_latch;

    logic [FRAME_W-1:0] w_frame;
    logic               w_accept;
    logic               w_phase_end;

    assign w_frame  = pack_frame(seven_seg_hms_i, dp_i, SEG_ACTIVE_LOW);
    assign w_accept = (r_state == ST_IDLE) && start_i;

    ser_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (w_accept),
        .en_i        (r_state != ST_IDLE),
        .phase_end_o (w_phase_end)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sclk   <= 1'b0;
            r_latch  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_shreg  <= w_frame;
                        r_bitcnt <= 6'd47;
                        r_busy   <= 1'b1;
                        r_sclk   <= 1'b0;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_phase_end) begin
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            r_sclk <= 1'b0;
                            // Last bit is not shifted out so the data pin
                            // keeps its value through LATCH and IDLE.
                            if (r_bitcnt == 6'd0) begin
                                r_latch <= 1'b1;
                                r_state <= ST_LATCH;
                            end else begin
                                r_shreg  <= {r_shreg[FRAME_W-2:0], 1'b0};
                                r_bitcnt <= r_bitcnt - 6'd1;
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (w_phase_end) begin
                        r_latch <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign ser_clk_o   = r_sclk;
    assign ser_data_o  = r_shreg[FRAME_W-1];
    assign ser_latch_o = r_latch;

endmodule
